// File: rtl/el2_exu_ffop_ctl_if.sv
// el2_exu_ffop_ctl_if: command/response and engine handshake bundle for the finite-field op controller
interface el2_exu_ffop_ctl_if #(
  parameter int OPW = 409,
  parameter int MW  = 2
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [2:0]     cmd_op;
  logic [MW-1:0]  cmd_mode;
  logic [31:0]    rs1;
  logic [31:0]    rs2;
  logic           rsp_valid;
  logic [31:0]    rsp_data;
  logic           rsp_err;
  logic           eng_start;
  logic           eng_abort;
  logic [MW-1:0]  eng_mode;
  logic [OPW-1:0] eng_a;
  logic [OPW-1:0] eng_b;
  logic           eng_done;
  logic [OPW-1:0] eng_result;
  modport slave (
    input  cmd_valid, cmd_op, cmd_mode, rs1, rs2, eng_done, eng_result,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, eng_start, eng_abort, eng_mode, eng_a, eng_b
  );
  modport master (
    output cmd_valid, cmd_op, cmd_mode, rs1, rs2, eng_done, eng_result,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, eng_start, eng_abort, eng_mode, eng_a, eng_b
  );
endinterface

// File: rtl/el2_exu_ffop_ctl.sv
// el2_exu_ffop_ctl: gathers wide operands from 64-bit beats, launches the field-multiply engine, returns the product 32 bits per read
module el2_exu_ffop_ctl #(
  parameter int OPW   = 409,
  parameter int NMODE = 4
) (
  input logic clk,
  input logic rst,
  el2_exu_ffop_ctl_if.slave bus
);
  localparam int NW = (OPW + 63) / 64;
  localparam int NR = (OPW + 31) / 32;
  localparam int CW = $clog2(NW + 1);
  localparam int RW = NR > 1 ? $clog2(NR) : 1;
  localparam logic [2:0] LDA_S = 3'd0, LDA = 3'd1, LDB_S = 3'd2, LDB = 3'd3;
  localparam logic [2:0] MUL = 3'd4, RD = 3'd5, ABORT = 3'd6;
  typedef enum logic {IDLE, RUN} state_t;
  state_t         state;
  logic [OPW-1:0] opa, opb, res_r;
  logic [CW-1:0]  cnt_a, cnt_b;
  logic           res_vld;
  logic           acc, mul_ok, rd_ok;
  logic [63:0]    beat;
  logic [32*NR-1:0] res_w;
  logic [31:0]    rd_word;
  // writes one beat into a zero-padded copy so bits at or above OPW fall away
  function automatic logic [OPW-1:0] put(input logic [OPW-1:0] cur, input logic [CW-1:0] idx, input logic [63:0] b);
    logic [64*NW-1:0] w;
    w = '0;
    w[OPW-1:0] = cur;
    w[64*idx +: 64] = b;
    return w[OPW-1:0];
  endfunction
  assign bus.cmd_ready = state == IDLE || bus.cmd_op == ABORT;
  assign acc           = bus.cmd_valid && bus.cmd_ready;
  assign beat          = {bus.rs2, bus.rs1};
  assign mul_ok        = 32'(cnt_a) == NW && 32'(cnt_b) == NW && 32'(bus.cmd_mode) < NMODE;
  assign rd_ok         = res_vld && bus.rs1 < 32'(NR);
  assign bus.eng_a     = opa;
  assign bus.eng_b     = opb;
  always_comb begin
    res_w = '0;
    res_w[OPW-1:0] = res_r;
    rd_word = res_w[32*bus.rs1[RW-1:0] +: 32];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      opa           <= '0;
      opb           <= '0;
      res_r         <= '0;
      cnt_a         <= '0;
      cnt_b         <= '0;
      res_vld       <= 1'b0;
      bus.eng_mode  <= '0;
      bus.eng_start <= 1'b0;
      bus.eng_abort <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.eng_start <= 1'b0;
      bus.eng_abort <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      if (acc) begin
        bus.rsp_valid <= 1'b1;
        case (bus.cmd_op)
          LDA_S: begin
            opa     <= put('0, '0, beat);
            cnt_a   <= CW'(1);
            res_vld <= 1'b0;
          end
          LDA: begin
            res_vld <= 1'b0;
            if (32'(cnt_a) < NW) begin
              opa   <= put(opa, cnt_a, beat);
              cnt_a <= cnt_a + 1'b1;
            end else bus.rsp_err <= 1'b1;
          end
          LDB_S: begin
            opb     <= put('0, '0, beat);
            cnt_b   <= CW'(1);
            res_vld <= 1'b0;
          end
          LDB: begin
            res_vld <= 1'b0;
            if (32'(cnt_b) < NW) begin
              opb   <= put(opb, cnt_b, beat);
              cnt_b <= cnt_b + 1'b1;
            end else bus.rsp_err <= 1'b1;
          end
          // a successful launch answers later, when the engine reports done
          MUL: begin
            if (mul_ok) begin
              bus.rsp_valid <= 1'b0;
              bus.eng_start <= 1'b1;
              bus.eng_mode  <= bus.cmd_mode;
              res_vld       <= 1'b0;
              state         <= RUN;
            end else bus.rsp_err <= 1'b1;
          end
          RD: begin
            if (rd_ok) bus.rsp_data <= rd_word;
            else bus.rsp_err <= 1'b1;
          end
          ABORT: begin
            if (state == RUN) begin
              bus.eng_abort <= 1'b1;
              state         <= IDLE;
            end
          end
          default: bus.rsp_err <= 1'b1;
        endcase
      end else if (state == RUN && bus.eng_done) begin
        res_r         <= bus.eng_result;
        res_vld       <= 1'b1;
        bus.rsp_valid <= 1'b1;
        bus.rsp_data  <= bus.eng_result[31:0];
        state         <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_el2_exu_ffop_ctl.sv
// tb_el2_exu_ffop_ctl: scoreboard bench for the finite-field op controller with a countdown engine model
module tb_el2_exu_ffop_ctl;
  localparam int OPW = 409;
  localparam logic [2:0] LDA_S = 3'd0, LDA = 3'd1, LDB_S = 3'd2, LDB = 3'd3;
  localparam logic [2:0] MUL = 3'd4, RD = 3'd5, ABORT = 3'd6, RSVD = 3'd7;
  typedef struct packed {logic err; logic [31:0] data;} rsp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int eng_lat = 10;
  int ecnt = 0;
  logic [OPW-1:0] res_val = '0;
  rsp_t exp_q[$];
  always #5 clk = ~clk;
  el2_exu_ffop_ctl_if #(.OPW(OPW), .MW(2)) bus();
  el2_exu_ffop_ctl #(.OPW(OPW), .NMODE(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  // engine: done arrives eng_lat cycles after the start cycle, cancelled by abort
  always @(negedge clk) begin
    if (bus.eng_start) ecnt = eng_lat + 1;
    else if (bus.eng_abort) ecnt = 0;
    else if (ecnt > 0) ecnt--;
    bus.eng_done = ecnt == 1;
    bus.eng_result = res_val;
  end
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid) begin
      rsp_t e;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected got err=%0b data=%h exp none", bus.rsp_err, bus.rsp_data);
      end else begin
        e = exp_q.pop_front();
        if ({bus.rsp_err, bus.rsp_data} !== e) begin
          n_fail++;
          $display("FAIL rsp got err=%0b data=%h exp err=%0b data=%h", bus.rsp_err, bus.rsp_data, e.err, e.data);
        end
      end
    end
  end
  task automatic send(input logic [2:0] op, input logic [1:0] mode, input logic [31:0] r1, input logic [31:0] r2,
                      input bit has_rsp, input logic err, input logic [31:0] data);
    if (has_rsp) exp_q.push_back({err, data});
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_mode = mode;
    bus.rs1 = r1;
    bus.rs2 = r2;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask
  task automatic load_a();
    send(LDA_S, 0, 32'h2, 32'h1, 1, 0, 0);
    for (int k = 1; k <= 6; k++) send(LDA, 0, 32'(k), 32'(k), 1, 0, 0);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = LDA_S;
    bus.cmd_mode = '0;
    bus.rs1 = '0;
    bus.rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%0b exp=1", bus.cmd_ready); end
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%0b exp=0", bus.rsp_valid); end
    n_tests++;
    if (bus.eng_start !== 1'b0) begin n_fail++; $display("FAIL reset_eng_start got=%0b exp=0", bus.eng_start); end
    n_tests++;
    if (bus.eng_a !== '0) begin n_fail++; $display("FAIL reset_eng_a got=%h exp=0", bus.eng_a); end
    rst = 1'b0;
  endtask
  task automatic test_full_load();
    load_a();
    send(LDB_S, 0, 32'h2, 32'h1, 1, 0, 0);
    for (int k = 1; k <= 6; k++) send(LDB, 0, 32'(k), 32'(k), 1, 0, 0);
    n_tests++;
    if (bus.eng_a[63:0] !== 64'h0000000100000002) begin n_fail++; $display("FAIL load_a_beat0 got=%h exp=0000000100000002", bus.eng_a[63:0]); end
    n_tests++;
    if (bus.eng_a[127:64] !== 64'h0000000100000001) begin n_fail++; $display("FAIL load_a_beat1 got=%h exp=0000000100000001", bus.eng_a[127:64]); end
    n_tests++;
    if (bus.eng_a[408:384] !== 25'h0000006) begin n_fail++; $display("FAIL load_a_top got=%h exp=0000006", bus.eng_a[408:384]); end
    n_tests++;
    if (bus.eng_b[63:0] !== 64'h0000000100000002) begin n_fail++; $display("FAIL load_b_beat0 got=%h exp=0000000100000002", bus.eng_b[63:0]); end
    n_tests++;
    if (bus.eng_b[408:384] !== 25'h0000006) begin n_fail++; $display("FAIL load_b_top got=%h exp=0000006", bus.eng_b[408:384]); end
  endtask
  task automatic test_overflow();
    logic [OPW-1:0] old_a;
    old_a = bus.eng_a;
    send(LDA, 0, 32'hdead_beef, 32'hcafe_f00d, 1, 1, 0);
    n_tests++;
    if (bus.eng_a !== old_a) begin n_fail++; $display("FAIL overflow_eng_a got=%h exp=%h", bus.eng_a, old_a); end
  endtask
  task automatic test_mul_read();
    int st_cyc = 0;
    int rsp_cyc = 0;
    logic [1:0] mode_seen = '0;
    res_val = (409'h1234_5678 << 32) | (409'h1 << 408);
    eng_lat = 10;
    send(MUL, 2, 0, 0, 1, 0, 32'h0);
    for (int i = 1; i <= 20; i++) begin
      if (bus.eng_start) st_cyc = i;
      if (bus.rsp_valid && rsp_cyc == 0) rsp_cyc = i;
      if (i == 5) mode_seen = bus.eng_mode;
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (st_cyc != 1) begin n_fail++; $display("FAIL mul_start_cycle got=%0d exp=1", st_cyc); end
    n_tests++;
    if (rsp_cyc != 12) begin n_fail++; $display("FAIL mul_rsp_cycle got=%0d exp=12", rsp_cyc); end
    n_tests++;
    if (mode_seen !== 2'd2) begin n_fail++; $display("FAIL mul_eng_mode got=%0d exp=2", mode_seen); end
    send(RD, 0, 1, 0, 1, 0, 32'h1234_5678);
    send(RD, 0, 0, 0, 1, 0, 32'h0);
    send(RD, 0, 12, 0, 1, 0, 32'h0100_0000);
    send(RD, 0, 13, 0, 1, 1, 0);
    send(LDA_S, 0, 5, 5, 1, 0, 0);
    send(RD, 0, 0, 0, 1, 1, 0);
  endtask
  task automatic test_errors();
    bit seen = 0;
    send(MUL, 1, 0, 0, 1, 1, 0);
    repeat (5) begin
      if (bus.eng_start) seen = 1;
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL short_eng_start got=1 exp=0"); end
    n_tests++;
    if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL short_idle_ready got=%0b exp=1", bus.cmd_ready); end
    send(RSVD, 0, 0, 0, 1, 1, 0);
    send(ABORT, 0, 0, 0, 1, 0, 0);
    n_tests++;
    if (bus.eng_abort !== 1'b0) begin n_fail++; $display("FAIL idle_abort_pulse got=%0b exp=0", bus.eng_abort); end
  endtask
  task automatic test_abort();
    load_a();
    eng_lat = 3;
    send(MUL, 1, 0, 0, 1, 0, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = LDA;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL run_ready_cyc%0d got=%0b exp=0", i, bus.cmd_ready); end
      @(posedge clk);
      #1;
    end
    bus.cmd_op = ABORT;
    @(negedge clk);
    #1;
    n_tests++;
    if (bus.eng_done !== 1'b1 || bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_setup got done=%0b ready=%0b exp done=1 ready=1", bus.eng_done, bus.cmd_ready);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    n_tests++;
    if (bus.eng_abort !== 1'b1) begin n_fail++; $display("FAIL abort_pulse got=%0b exp=1", bus.eng_abort); end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.eng_abort !== 1'b0) begin n_fail++; $display("FAIL abort_pulse_width got=%0b exp=0", bus.eng_abort); end
    bus.cmd_op = LDA;
    #1;
    n_tests++;
    if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort_idle_ready got=%0b exp=1", bus.cmd_ready); end
    send(RD, 0, 0, 0, 1, 1, 0);
    repeat (5) @(posedge clk);
    #1;
  endtask
  initial begin
    test_reset();
    test_full_load();
    test_overflow();
    test_mul_read();
    test_errors();
    test_abort();
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rsp_missing got=%0d pending exp=0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
